aqp_ebus_arbiter: RTL and testbench

- Sequences ownership of the external Z80 bus (ebus_a/d/rd_n/wr_n/mreq_n/iorq_n) between the CPU (internal T80 or external Z80) and two secondary bus masters: the ESP SPI bus master (req[0]) and a future DMA engine (req[1]).
- Runs the BUSREQ#/BUSACK# handshake with the CPU, inserts tristate turnaround cycles, and arbitrates round-robin.
- Drives one-hot grants that steer the top-level ebus mux, and flags CPUs that never acknowledge.

---
 rtl/aqp_ebus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_aqp_ebus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aqp_ebus_arbiter.sv
// External Z80 bus arbiter: BUSREQ#/BUSACK# handshake with the CPU, tristate
// turnaround, and round-robin one-hot grants for the SPI master and DMA engine.
module aqp_ebus_arbiter #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TURN    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       use_t80,
  input  logic       busak_n,
  output logic       busrq_n,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       bus_drive,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clr
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_TURN_ON  = 3'd2,
    ST_GRANT    = 3'd3,
    ST_TURN_OFF = 3'd4,
    ST_RELEASE  = 3'd5
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] TURN_LAST    = 16'(TURN - 1);

  state_t      state_r;
  logic        sel_r;
  logic        last_r;
  logic        handover_r;
  logic [15:0] wait_cnt_r;
  logic        sync1_r;
  logic        sync2_r;
  logic        busrq_n_r;
  logic [1:0]  grant_r;
  logic        bus_drive_r;
  logic        busy_r;
  logic        timeout_err_r;
  logic        busak_s;
  logic        other_s;

  // One-hot grant vector for the selected requester.
  function automatic logic [1:0] grant_of(input logic s);
    return s ? 2'b10 : 2'b01;
  endfunction

  // On a tie the requester that did not own the bus last wins.
  function automatic logic pick_sel(input logic [1:0] r, input logic last);
    return (r == 2'b11) ? ~last : r[1];
  endfunction

  assign busak_s     = use_t80 ? busak_n : sync2_r;
  assign other_s     = ~sel_r;
  assign busrq_n     = busrq_n_r;
  assign grant       = grant_r;
  assign bus_drive   = bus_drive_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;

  // Two-flop synchroniser for an external Z80's BUSACK#.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= busak_n;
      sync2_r <= sync1_r;
    end
  end

  // Arbitration FSM with registered handshake, grant and error outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      sel_r         <= 1'b0;
      last_r        <= 1'b1;
      handover_r    <= 1'b0;
      wait_cnt_r    <= 16'd0;
      busrq_n_r     <= 1'b1;
      grant_r       <= 2'b00;
      bus_drive_r   <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      // A timeout set later in this block overrides a same-cycle clear.
      if (err_clr) begin
        timeout_err_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (req != 2'b00) begin
            sel_r      <= pick_sel(req, last_r);
            busrq_n_r  <= 1'b0;
            wait_cnt_r <= 16'd0;
            busy_r     <= 1'b1;
            state_r    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!busak_s) begin
            wait_cnt_r <= 16'd0;
            state_r    <= ST_TURN_ON;
          end else if (!req[sel_r]) begin
            busrq_n_r <= 1'b1;
            state_r   <= ST_RELEASE;
          end else if (wait_cnt_r == TIMEOUT_LAST) begin
            timeout_err_r <= 1'b1;
            busrq_n_r     <= 1'b1;
            state_r       <= ST_RELEASE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_TURN_ON: begin
          if (wait_cnt_r == TURN_LAST) begin
            grant_r     <= grant_of(sel_r);
            bus_drive_r <= 1'b1;
            state_r     <= ST_GRANT;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_GRANT: begin
          if (!req[sel_r]) begin
            grant_r     <= 2'b00;
            bus_drive_r <= 1'b0;
            last_r      <= sel_r;
            wait_cnt_r  <= 16'd0;
            state_r     <= ST_TURN_OFF;
          end
        end
        ST_TURN_OFF: begin
          if (wait_cnt_r != TURN_LAST) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end else if (req[other_s] && !handover_r) begin
            // Hand the bus straight over without waking the CPU.
            sel_r      <= other_s;
            handover_r <= 1'b1;
            wait_cnt_r <= 16'd0;
            state_r    <= ST_TURN_ON;
          end else begin
            busrq_n_r  <= 1'b1;
            handover_r <= 1'b0;
            state_r    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          handover_r <= 1'b0;
          if (busak_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busrq_n_r   <= 1'b1;
          grant_r     <= 2'b00;
          bus_drive_r <= 1'b0;
          busy_r      <= 1'b0;
          handover_r  <= 1'b0;
          wait_cnt_r  <= 16'd0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aqp_ebus_arbiter.sv
// Directed self-checking bench for aqp_ebus_arbiter (TIMEOUT=16, TURN=2).
module tb_aqp_ebus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       use_t80;
  logic       busak_n;
  logic       busrq_n;
  logic [1:0] req;
  logic [1:0] grant;
  logic       bus_drive;
  logic       busy;
  logic       timeout_err;
  logic       err_clr;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  aqp_ebus_arbiter #(.TIMEOUT(16), .TURN(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .use_t80    (use_t80),
    .busak_n    (busak_n),
    .busrq_n    (busrq_n),
    .req        (req),
    .grant      (grant),
    .bus_drive  (bus_drive),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  // Advance n clock edges, sampling 1 time unit after each edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk1("drive_eq_grant", bus_drive, |grant);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req     = 2'b00;
    busak_n = 1'b1;
    err_clr = 1'b0;
    use_t80 = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; use_t80 = 1'b1; busak_n = 1'b1; req = 2'b00; err_clr = 1'b0;
    tick(2);
    chk1("rst_busrq_n", busrq_n, 1'b1);
    chk2("rst_grant", grant, 2'b00);
    chk1("rst_bus_drive", bus_drive, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_timeout_err", timeout_err, 1'b0);
    reset = 1'b0;
    tick(1);
    chk1("idle_busy", busy, 1'b0);

    // Single SPI burst, internal T80
    req = 2'b01;
    tick(1);
    chk1("t1_busrq_low", busrq_n, 1'b0);
    chk1("t1_busy", busy, 1'b1);
    tick(2);
    chk2("t1_wait_ack", grant, 2'b00);
    busak_n = 1'b0;
    tick(1);
    chk2("t1_dead1", grant, 2'b00);
    tick(1);
    chk2("t1_dead2", grant, 2'b00);
    tick(1);
    chk2("t1_grant", grant, 2'b01);
    chk1("t1_drive", bus_drive, 1'b1);
    tick(4);
    chk2("t1_grant_held", grant, 2'b01);
    req = 2'b00;
    tick(1);
    chk2("t1_grant_drop", grant, 2'b00);
    chk1("t1_busrq_still_low", busrq_n, 1'b0);
    tick(1);
    chk1("t1_turnoff", busrq_n, 1'b0);
    tick(1);
    chk1("t1_busrq_high", busrq_n, 1'b1);
    chk1("t1_busy_release", busy, 1'b1);
    tick(1);
    chk1("t1_wait_busak", busy, 1'b1);
    busak_n = 1'b1;
    tick(1);
    chk1("t1_idle", busy, 1'b0);

    // Tie after reset, handover, then no second handover
    do_reset();
    req = 2'b11;
    tick(1);
    chk1("t2_busrq_low", busrq_n, 1'b0);
    busak_n = 1'b0;
    tick(2);
    chk2("t2_dead", grant, 2'b00);
    tick(1);
    chk2("t2_first_grant", grant, 2'b01);
    req = 2'b10;
    tick(1);
    chk2("t2_drop0", grant, 2'b00);
    tick(2);
    chk1("t2_handover_busrq", busrq_n, 1'b0);
    chk2("t2_handover_dead1", grant, 2'b00);
    tick(1);
    chk2("t2_handover_dead2", grant, 2'b00);
    tick(1);
    chk2("t2_grant1", grant, 2'b10);
    chk1("t2_busrq_held", busrq_n, 1'b0);
    req = 2'b11;
    tick(1);
    chk2("t2_other_ignored", grant, 2'b10);
    req = 2'b01;
    tick(1);
    chk2("t2_drop1", grant, 2'b00);
    tick(2);
    chk1("t2_no_second_handover", busrq_n, 1'b1);
    chk2("t2_release_grant", grant, 2'b00);
    busak_n = 1'b1;
    tick(1);
    chk1("t2_idle", busy, 1'b0);
    tick(1);
    chk1("t2_rereq", busrq_n, 1'b0);
    busak_n = 1'b0;
    tick(2);
    chk2("t2_rereq_dead", grant, 2'b00);
    tick(1);
    chk2("t2_regrant0", grant, 2'b01);
    req = 2'b00;
    tick(3);
    chk1("t2_final_release", busrq_n, 1'b1);
    busak_n = 1'b1;
    tick(1);
    chk1("t2_final_idle", busy, 1'b0);

    // External Z80 through synchroniser
    use_t80 = 1'b0;
    req = 2'b01;
    tick(1);
    chk1("t3_busrq_low", busrq_n, 1'b0);
    #3 busak_n = 1'b0;
    tick(3);
    chk2("t3_sync_wait1", grant, 2'b00);
    tick(1);
    chk2("t3_sync_wait2", grant, 2'b00);
    tick(1);
    chk2("t3_grant", grant, 2'b01);
    req = 2'b00;
    tick(1);
    chk2("t3_drop", grant, 2'b00);
    tick(2);
    chk1("t3_busrq_high", busrq_n, 1'b1);
    busak_n = 1'b1;
    tick(2);
    chk1("t3_sync_release_wait", busy, 1'b1);
    tick(1);
    chk1("t3_idle", busy, 1'b0);
    use_t80 = 1'b1;

    // BUSACK# timeout, sticky error, clear
    req = 2'b01;
    tick(1);
    for (int k = 0; k < 15; k++) begin
      tick(1);
      chk2("t4_no_grant", grant, 2'b00);
    end
    chk1("t4_pre_timeout", timeout_err, 1'b0);
    chk1("t4_pre_busrq", busrq_n, 1'b0);
    tick(1);
    chk1("t4_timeout", timeout_err, 1'b1);
    chk1("t4_busrq_high", busrq_n, 1'b1);
    chk2("t4_grant", grant, 2'b00);
    req = 2'b00;
    tick(1);
    chk1("t4_idle", busy, 1'b0);
    tick(2);
    chk1("t4_sticky", timeout_err, 1'b1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk1("t4_cleared", timeout_err, 1'b0);
    req = 2'b01;
    tick(16);
    err_clr = 1'b1;
    tick(1);
    chk1("t4_set_wins", timeout_err, 1'b1);
    err_clr = 1'b0;
    req = 2'b00;
    tick(1);
    chk1("t4_set_sticky", timeout_err, 1'b1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk1("t4_cleared2", timeout_err, 1'b0);

    // Withdrawal in REQ, then ack beating withdrawal
    req = 2'b01;
    tick(2);
    req = 2'b00;
    tick(1);
    chk1("t5_withdraw_busrq", busrq_n, 1'b1);
    chk2("t5_withdraw_grant", grant, 2'b00);
    tick(1);
    chk1("t5_idle", busy, 1'b0);
    req = 2'b01;
    tick(1);
    busak_n = 1'b0;
    req = 2'b00;
    tick(1);
    chk1("t5_ack_wins", busrq_n, 1'b0);
    tick(2);
    chk2("t5_ack_grant", grant, 2'b01);
    tick(1);
    chk2("t5_ack_drop", grant, 2'b00);
    tick(2);
    chk1("t5_ack_release", busrq_n, 1'b1);
    busak_n = 1'b1;
    tick(1);
    chk1("t5_ack_idle", busy, 1'b0);

    // Reset during GRANT
    req = 2'b01;
    tick(1);
    busak_n = 1'b0;
    tick(3);
    chk2("t6_grant", grant, 2'b01);
    #2 reset = 1'b1;
    #1;
    chk2("t6_async_grant", grant, 2'b00);
    chk1("t6_async_drive", bus_drive, 1'b0);
    chk1("t6_async_busrq", busrq_n, 1'b1);
    chk1("t6_async_busy", busy, 1'b0);
    busak_n = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk1("t6_fresh_busrq", busrq_n, 1'b0);
    chk2("t6_fresh_nogrant", grant, 2'b00);
    busak_n = 1'b0;
    tick(3);
    chk2("t6_fresh_grant", grant, 2'b01);
    req = 2'b00;
    tick(3);
    chk1("t6_release", busrq_n, 1'b1);
    busak_n = 1'b1;
    tick(1);
    chk1("t6_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
